// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock divider: FSM encoding and
// the smallest divisor that still yields a square wave.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int DIV_MIN = 2;

endpackage

// File: rtl/clk_div_core.sv
// Period counter for the divider: counts 0..div-1, flags the wrap and reports
// whether the next count lies in the high half of the period.
module clk_div_core #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_CNT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             park,
    input  logic [WIDTH-1:0] div,
    input  logic [WIDTH-1:0] park_div,
    output logic             wrap,
    output logic             hi_next
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_nx;
    logic [WIDTH:0]   half;

    // One extra bit keeps cnt+1 and div+1 from overflowing at all-ones.
    assign wrap    = ({1'b0, cnt_q} + (WIDTH+1)'(1)) >= {1'b0, div};
    assign cnt_nx  = wrap ? '0 : cnt_q + WIDTH'(1);
    assign half    = ({1'b0, div} + (WIDTH+1)'(1)) >> 1;
    assign hi_next = {1'b0, cnt_nx} < half;

    // Parking at div-1 makes the first enabled edge wrap straight to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_CNT;
        end else if (park) begin
            cnt_q <= park_div - WIDTH'(1);
        end else if (run) begin
            cnt_q <= cnt_nx;
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider: run/idle FSM, staged divisor and load/ack
// handshake around the period counter; all outputs are registered.
module clk_div_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic             err,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] div_cur
);
    import clkdiv_pkg::*;

    // Handshake: div_load is a one-cycle valid with no back-pressure (always
    // accepted). Each accepted value is answered by one div_ack pulse when it
    // becomes active (a later load before then replaces it); a value below
    // DIV_MIN is answered by one err pulse on the next cycle and dropped.

    state_t           state_q, state_nx;
    logic [WIDTH-1:0] div_cur_q, div_cur_nx;
    logic [WIDTH-1:0] staged_q, staged_nx;
    logic             ack_nx, err_nx, clk_nx, tick_nx;
    logic             run, park, wrap, hi_next;
    logic [WIDTH-1:0] park_div;
    logic             load_ok, load_bad;

    assign load_ok  = div_load && (div_in >= WIDTH'(DIV_MIN));
    assign load_bad = div_load && (div_in <  WIDTH'(DIV_MIN));
    assign div_cur  = div_cur_q;

    clk_div_core #(
        .WIDTH   (WIDTH),
        .RST_CNT (WIDTH'(DEFAULT_DIV - 1))
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .park     (park),
        .div      (div_cur_q),
        .park_div (park_div),
        .wrap     (wrap),
        .hi_next  (hi_next)
    );

    always_comb begin
        state_nx   = state_q;
        div_cur_nx = div_cur_q;
        staged_nx  = staged_q;
        ack_nx     = 1'b0;
        err_nx     = load_bad;
        clk_nx     = 1'b0;
        tick_nx    = 1'b0;
        run        = 1'b0;
        park       = 1'b0;
        park_div   = div_cur_q;
        case (state_q)
            IDLE: begin
                if (load_ok) begin
                    div_cur_nx = div_in;
                    ack_nx     = 1'b1;
                end
                if (en) begin
                    run      = 1'b1;
                    clk_nx   = 1'b1;
                    tick_nx  = 1'b1;
                    state_nx = RUN;
                end else begin
                    park     = 1'b1;
                    park_div = div_cur_nx;
                end
            end
            RUN, PEND: begin
                if (!en) begin
                    // Leaving run applies whatever is pending right away.
                    if (load_ok) begin
                        div_cur_nx = div_in;
                    end else if (state_q == PEND) begin
                        div_cur_nx = staged_q;
                    end
                    ack_nx   = load_ok || (state_q == PEND);
                    park     = 1'b1;
                    park_div = div_cur_nx;
                    state_nx = IDLE;
                end else begin
                    run     = 1'b1;
                    clk_nx  = hi_next;
                    tick_nx = wrap;
                    if ((state_q == PEND) && wrap) begin
                        div_cur_nx = staged_q;
                        ack_nx     = 1'b1;
                        state_nx   = RUN;
                    end
                    if (load_ok) begin
                        staged_nx = div_in;
                        state_nx  = PEND;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_cur_q <= WIDTH'(DEFAULT_DIV);
            staged_q  <= '0;
            div_ack   <= 1'b0;
            err       <= 1'b0;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
        end else begin
            state_q   <= state_nx;
            div_cur_q <= div_cur_nx;
            staged_q  <= staged_nx;
            div_ack   <= ack_nx;
            err       <= err_nx;
            clk_out   <= clk_nx;
            tick      <= tick_nx;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: vector table, hand-written corner sequences and a
// randomized run checked against a period/phase model of the divider.
module tb_clk_div_prog;

    localparam int W    = 16;
    localparam int DEFN = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] div_in;
    logic         div_load;
    logic         div_ack;
    logic         err;
    logic         clk_out;
    logic         tick;
    logic [W-1:0] div_cur;

    int checks = 0;
    int errors = 0;

    clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(DEFN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .div_ack  (div_ack),
        .err      (err),
        .clk_out  (clk_out),
        .tick     (tick),
        .div_cur  (div_cur)
    );

    always #5 clk = ~clk;

    // Reference model: running flag, position within the period, divisor in
    // effect and a queue holding the one divisor waiting for the next wrap.
    bit           m_run;
    int           m_phase;
    int           m_n;
    logic [W-1:0] exp_q[$];
    bit           m_clk, m_tick, m_ack, m_err;

    typedef struct {
        bit           en;
        bit           ld;
        logic [W-1:0] din;
        bit           e_clk;
        bit           e_tick;
        bit           e_ack;
        bit           e_err;
        logic [W-1:0] e_div;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_phase = 0;
        m_n = DEFN;
        exp_q.delete();
        m_clk = 1'b0;
        m_tick = 1'b0;
        m_ack = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit l, input logic [W-1:0] d);
        bit ok;
        ok    = l && (d >= 2);
        m_err = l && (d < 2);
        m_ack = 1'b0;
        if (!m_run) begin
            if (ok) begin
                m_n = int'(d);
                m_ack = 1'b1;
            end
            if (e) begin
                m_run = 1'b1;
                m_phase = 0;
            end
        end else if (!e) begin
            if (ok) m_n = int'(d);
            else if (exp_q.size() > 0) m_n = int'(exp_q[0]);
            m_ack = ok || (exp_q.size() > 0);
            exp_q.delete();
            m_run = 1'b0;
        end else begin
            m_phase = (m_phase + 1) % m_n;
            if (m_phase == 0 && exp_q.size() > 0) begin
                m_n = int'(exp_q.pop_front());
                m_ack = 1'b1;
            end
            if (ok) begin
                exp_q.delete();
                exp_q.push_back(d);
            end
        end
        m_clk  = m_run && (m_phase < (m_n + 1) / 2);
        m_tick = m_run && (m_phase == 0);
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
    task automatic cyc(input bit e, input bit l, input logic [W-1:0] d);
        en = e;
        div_load = l;
        div_in = d;
        @(posedge clk);
        model_step(e, l, d);
        #1;
        chk("clk_out", clk_out, m_clk);
        chk("tick", tick, m_tick);
        chk("div_ack", div_ack, m_ack);
        chk("err", err, m_err);
        chk("div_cur", div_cur, m_n);
        div_load = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        div_load = 1'b0;
        div_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_div_ack", div_ack, 0);
        chk("rst_err", err, 0);
        chk("rst_div_cur", div_cur, DEFN);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int acks;
        int ack_i;
        int tick_i;
        bit pat5[5];

        // en, ld, din | clk, tick, ack, err, div
        vecs[0]  = '{1'b0, 1'b1, 16'd4, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4};
        vecs[1]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4};
        vecs[2]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4};
        vecs[3]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4};
        vecs[4]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4};
        vecs[5]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4};
        vecs[6]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4};
        vecs[7]  = '{1'b1, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd4};
        vecs[8]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4};
        vecs[9]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4};
        vecs[10] = '{1'b1, 1'b1, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4};
        vecs[11] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4};
        vecs[12] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4};
        vecs[13] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2};
        vecs[14] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
        vecs[15] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2};
        vecs[16] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
        vecs[17] = '{1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};
        pat5 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            en = vecs[i].en;
            div_load = vecs[i].ld;
            div_in = vecs[i].din;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_clk_out", i), clk_out, vecs[i].e_clk);
            chk($sformatf("vec%0d_tick", i), tick, vecs[i].e_tick);
            chk($sformatf("vec%0d_div_ack", i), div_ack, vecs[i].e_ack);
            chk($sformatf("vec%0d_err", i), err, vecs[i].e_err);
            chk($sformatf("vec%0d_div_cur", i), div_cur, vecs[i].e_div);
            div_load = 1'b0;
        end

        // N=5: high three cycles, low two.
        do_reset();
        cyc(1'b0, 1'b1, 16'd5);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 16'd0);
            chk("pat5_clk_out", clk_out, pat5[i % 5]);
        end

        // N=8, reload 3 at cnt=2 then 6 at cnt=5: one ack, then a clean 6-cycle period.
        do_reset();
        cyc(1'b0, 1'b1, 16'd8);
        cyc(1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 10 && m_phase != 2; i++) cyc(1'b1, 1'b0, 16'd0);
        cyc(1'b1, 1'b1, 16'd3);
        for (int i = 0; i < 10 && m_phase != 5; i++) cyc(1'b1, 1'b0, 16'd0);
        cyc(1'b1, 1'b1, 16'd6);
        acks = 0;
        ack_i = -1;
        tick_i = -1;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 16'd0);
            if (div_ack) begin
                acks++;
                ack_i = i;
            end else if (tick && ack_i >= 0 && tick_i < 0) begin
                tick_i = i;
            end
        end
        chk("reload_ack_count", acks, 1);
        chk("reload_div_cur", div_cur, 6);
        chk("reload_period", tick_i - ack_i, 6);

        // Drop en at cnt=3 of N=4, idle 5 cycles, re-raise.
        do_reset();
        cyc(1'b0, 1'b1, 16'd4);
        cyc(1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 10 && m_phase != 3; i++) cyc(1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 16'd0);
            chk("idle_clk_out", clk_out, 0);
        end
        cyc(1'b1, 1'b0, 16'd0);
        chk("reraise_tick", tick, 1);
        chk("reraise_clk_out", clk_out, 1);

        // Asynchronous reset mid-period with a load pending.
        do_reset();
        cyc(1'b0, 1'b1, 16'd7);
        cyc(1'b1, 1'b0, 16'd0);
        cyc(1'b1, 1'b0, 16'd0);
        cyc(1'b1, 1'b1, 16'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_clk_out", clk_out, 0);
        chk("arst_tick", tick, 0);
        chk("arst_div_ack", div_ack, 0);
        chk("arst_div_cur", div_cur, DEFN);
        #2;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 16'd0);
            chk("arst_no_ack", div_ack, 0);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 15) != 0, $urandom_range(0, 7) == 0,
                W'($urandom_range(0, 9)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
